// File: rtl/execute_muldiv.sv
// execute_muldiv: RV32IM execute stage with a single-cycle ALU, branch/target logic and a multi-cycle mul/div unit
// Ports: clk_i/rst_ni (sync, active low); RD1E_i/RD2E_i register operands; PCE_i/PCPlus4E_i/ImmExtE_i;
//   ALUCtrl_i 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,A pass SrcB (others ADD);
//   ALUSrcB_i imm select; JumpCtrl_i JALR target; BranchSrc_i 1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU (others never);
//   RdD_i; MulDivEn_i/MulDivOp_i M-extension op; FlushE_i; ResultW_i/ALUResultM_i and ForwardA/BEctrl_i forwarding;
//   outputs ALUResultE_o, WriteDataE_o, PCPlus4E_o, PCTargetE_o, RdE_o, branchTaken_o, StallE_o.
module execute_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] RD1E_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic [DATA_WIDTH-1:0] ImmExtE_i,
  input  logic [3:0]            ALUCtrl_i,
  input  logic                  ALUSrcB_i,
  input  logic                  JumpCtrl_i,
  input  logic [2:0]            BranchSrc_i,
  input  logic [4:0]            RdD_i,
  input  logic                  MulDivEn_i,
  input  logic [2:0]            MulDivOp_i,
  input  logic                  FlushE_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [1:0]            ForwardAEctrl_i,
  input  logic [1:0]            ForwardBEctrl_i,
  output logic [DATA_WIDTH-1:0] ALUResultE_o,
  output logic [DATA_WIDTH-1:0] WriteDataE_o,
  output logic [DATA_WIDTH-1:0] PCPlus4E_o,
  output logic [DATA_WIDTH-1:0] PCTargetE_o,
  output logic [4:0]            RdE_o,
  output logic                  branchTaken_o,
  output logic                  StallE_o
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(W - 1);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0] res_q, res_n, a_q, a_n, b_q, b_n, quo_q, quo_n, rem_q, rem_n;
  logic [2:0] op_q, op_n;
  logic [W-1:0] src_a, src_b, alu;
  logic [CW-1:0] shamt;
  logic eq, lt, ltu, br;
  always_comb src_a = (ForwardAEctrl_i == 2'b01) ? ResultW_i : (ForwardAEctrl_i == 2'b10) ? ALUResultM_i : RD1E_i;
  always_comb WriteDataE_o = (ForwardBEctrl_i == 2'b01) ? ResultW_i : (ForwardBEctrl_i == 2'b10) ? ALUResultM_i : RD2E_i;
  assign src_b = ALUSrcB_i ? ImmExtE_i : WriteDataE_o;
  assign shamt = src_b[CW-1:0];
  always_comb
    case (ALUCtrl_i)
      4'h1: alu = src_a - src_b;
      4'h2: alu = src_a & src_b;
      4'h3: alu = src_a | src_b;
      4'h4: alu = src_a ^ src_b;
      4'h5: alu = src_a << shamt;
      4'h6: alu = src_a >> shamt;
      4'h7: alu = W'($signed(src_a) >>> shamt);
      4'h8: alu = W'($signed(src_a) < $signed(src_b));
      4'h9: alu = W'(src_a < src_b);
      4'hA: alu = src_b;
      default: alu = src_a + src_b;
    endcase
  assign eq = src_a == src_b;
  assign lt = $signed(src_a) < $signed(src_b);
  assign ltu = src_a < src_b;
  always_comb
    case (BranchSrc_i)
      3'd1: br = eq;
      3'd2: br = ~eq;
      3'd3: br = lt;
      3'd4: br = ~lt;
      3'd5: br = ltu;
      3'd6: br = ~ltu;
      default: br = 1'b0;
    endcase
  assign branchTaken_o = br & ~MulDivEn_i;
  assign PCTargetE_o = JumpCtrl_i ? alu : PCE_i + ImmExtE_i;
  assign PCPlus4E_o = PCPlus4E_i;
  assign RdE_o = RdD_i;
  assign ALUResultE_o = (state == DONE) ? res_q : alu;
  // M ops take the post-forwarding register operands regardless of ALUSrcB_i
  logic start, d_zero, d_ovf;
  logic [W-1:0] spec_res, a_mag;
  assign start = (state == IDLE) & MulDivEn_i & ~FlushE_i;
  assign d_zero = ~|WriteDataE_o;
  assign d_ovf = ~MulDivOp_i[0] & (src_a == MIN) & (&WriteDataE_o);
  assign spec_res = MulDivOp_i[1] ? (d_zero ? src_a : '0) : (d_zero ? '1 : MIN);
  assign a_mag = (~MulDivOp_i[0] & src_a[W-1]) ? -src_a : src_a;
  assign StallE_o = rst_ni & (start | (state == MUL) | (state == DIV));
  // The product of the latched operands is a multicycle path of MUL_CYCLES clocks
  logic a_sx, b_sx;
  logic [2*W-1:0] mul_a, mul_b, prod;
  logic [W-1:0] mul_res;
  assign a_sx = (op_q[1:0] != 2'b11) & a_q[W-1];
  assign b_sx = (op_q[1:0] == 2'b01) & b_q[W-1];
  assign mul_a = {{W{a_sx}}, a_q};
  assign mul_b = {{W{b_sx}}, b_q};
  assign prod = mul_a * mul_b;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  // Restoring division on magnitudes; quo_q shifts the dividend out and the quotient in
  logic d_sgn, take;
  logic [W-1:0] b_mag, quo_step, rem_step, q_fix, r_fix, div_res;
  logic [W:0] rem_sh, diff;
  assign d_sgn = ~op_q[0];
  assign b_mag = (d_sgn & b_q[W-1]) ? -b_q : b_q;
  assign rem_sh = {rem_q, quo_q[W-1]};
  assign diff = rem_sh - {1'b0, b_mag};
  assign take = ~diff[W];
  assign quo_step = {quo_q[W-2:0], take};
  assign rem_step = take ? diff[W-1:0] : rem_sh[W-1:0];
  assign q_fix = (d_sgn & (a_q[W-1] ^ b_q[W-1])) ? -quo_step : quo_step;
  assign r_fix = (d_sgn & a_q[W-1]) ? -rem_step : rem_step;
  assign div_res = op_q[1] ? r_fix : q_fix;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    res_n = res_q;
    a_n = a_q;
    b_n = b_q;
    op_n = op_q;
    quo_n = quo_q;
    rem_n = rem_q;
    case (state)
      IDLE:
        if (start) begin
          a_n = src_a;
          b_n = WriteDataE_o;
          op_n = MulDivOp_i;
          if (!MulDivOp_i[2]) begin
            state_n = MUL;
            cnt_n = MUL_INIT;
          end else if (d_zero | d_ovf) begin
            state_n = DONE;
            res_n = spec_res;
          end else begin
            state_n = DIV;
            cnt_n = DIV_INIT;
            quo_n = a_mag;
            rem_n = '0;
          end
        end
      MUL: begin
        cnt_n = cnt - CW'(1);
        if (cnt == '0) begin
          state_n = DONE;
          res_n = mul_res;
        end
      end
      DIV: begin
        cnt_n = cnt - CW'(1);
        quo_n = quo_step;
        rem_n = rem_step;
        if (cnt == '0) begin
          state_n = DONE;
          res_n = div_res;
        end
      end
      DONE: state_n = IDLE;
    endcase
    if (FlushE_i) begin
      state_n = IDLE;
      res_n = res_q;
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      res_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      res_q <= res_n;
      a_q <= a_n;
      b_q <= b_n;
      op_q <= op_n;
      quo_q <= quo_n;
      rem_q <= rem_n;
    end
endmodule
